// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory stage
// Purpose: load FSM state encoding and control-bus bit positions used by
//          mem_stage_sb and mem_sb_fifo.
// Ports:   none (package).
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LD_REQ  = 2'd1,
    ST_LD_WAIT = 2'd2
  } mem_state_e;

  localparam int CM_LOAD_BIT  = 0;
  localparam int CM_STORE_BIT = 1;

endpackage

// File: rtl/mem_sb_fifo.sv
// rtl/mem_sb_fifo.sv - store buffer: circular storage, pointers, count, forwarding match
// Purpose: holds committed stores {addr, data} until they drain to memory.
//          Under MEM_SB_FWD_EN a match port reports the youngest entry whose
//          address equals match_addr; without the macro no comparators exist.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   push, push_addr/data   write at tail
//   pop                    retire head
//   head_addr/head_data    oldest entry
//   count                  occupied entries
//   match_addr/hit/data    forwarding lookup (MEM_SB_FWD_EN only)
module mem_sb_fifo
  import mem_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [XLEN-1:0]            push_addr,
  input  logic [XLEN-1:0]            push_data,
  input  logic                       pop,
  output logic [XLEN-1:0]            head_addr,
  output logic [XLEN-1:0]            head_data,
  output logic [$clog2(SB_DEPTH):0]  count
`ifdef MEM_SB_FWD_EN
  ,
  input  logic [XLEN-1:0]            match_addr,
  output logic                       match_hit,
  output logic [XLEN-1:0]            match_data
`endif
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] addr_mem [SB_DEPTH];
  logic [XLEN-1:0] data_mem [SB_DEPTH];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Contents need no reset: count=0 makes every slot dead.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_q] <= push_addr;
      data_mem[tail_q] <= push_data;
    end
  end

  assign head_addr = addr_mem[head_q];
  assign head_data = data_mem[head_q];
  assign count     = count_q;

`ifdef MEM_SB_FWD_EN
  logic [PW-1:0] scan_idx;

  // Walk oldest to youngest so the last live hit is the youngest store.
  always_comb begin
    match_hit  = 1'b0;
    match_data = '0;
    scan_idx   = head_q;
    for (int i = 0; i < SB_DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_mem[scan_idx] == match_addr)) begin
        match_hit  = 1'b1;
        match_data = data_mem[scan_idx];
      end
    end
  end
`endif

endmodule

// File: rtl/mem_stage_sb.sv
// rtl/mem_stage_sb.sv - pipeline memory stage with store buffer and load FSM
// Purpose: registers ALU/flag/writeback results (latency 1), buffers stores and
//          drains them to memory when idle, and runs loads through
//          IDLE -> LD_REQ -> LD_WAIT. Optional macro MEM_SB_FWD_EN enables
//          store-to-load forwarding from the buffer.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   stall                       hold registered outputs, block acceptance
//   in_valid/in_ready           op handshake
//   alu_in, wdata_in, Z_in      op payload; cntrl_m_in bit0 load, bit1 store
//   cntrl_w_in                  writeback control passed through
//   out_valid, alu_out, mem_out, Z_out, cntrl_w_out   registered results
//   dmem_req/we/addr/wdata      memory request; dmem_gnt accepts it
//   dmem_rvalid/dmem_rdata      load return
//   sb_count                    store-buffer occupancy
module mem_stage_sb
  import mem_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4,
  parameter int CTRL_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            alu_in,
  input  logic [XLEN-1:0]            wdata_in,
  input  logic [3:0]                 Z_in,
  input  logic [CTRL_W-1:0]          cntrl_m_in,
  input  logic [CTRL_W-1:0]          cntrl_w_in,
  output logic                       out_valid,
  output logic [XLEN-1:0]            alu_out,
  output logic [XLEN-1:0]            mem_out,
  output logic [3:0]                 Z_out,
  output logic [CTRL_W-1:0]          cntrl_w_out,
  output logic                       dmem_req,
  output logic                       dmem_we,
  output logic [XLEN-1:0]            dmem_addr,
  output logic [XLEN-1:0]            dmem_wdata,
  input  logic                       dmem_gnt,
  input  logic                       dmem_rvalid,
  input  logic [XLEN-1:0]            dmem_rdata,
  output logic [$clog2(SB_DEPTH):0]  sb_count
);

  localparam int CW = $clog2(SB_DEPTH) + 1;

  mem_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   alu_out_q, alu_out_d;
  logic [XLEN-1:0]   mem_out_q, mem_out_d;
  logic [3:0]        z_out_q, z_out_d;
  logic [CTRL_W-1:0] cntrl_w_out_q, cntrl_w_out_d;
  // Load context captured at acceptance; ld_alu doubles as the read address.
  logic [XLEN-1:0]   ld_alu_q, ld_alu_d;
  logic [3:0]        ld_z_q, ld_z_d;
  logic [CTRL_W-1:0] ld_cw_q, ld_cw_d;
  // Read data that returned while stalled waits here until the stall clears.
  logic [XLEN-1:0]   ld_data_q, ld_data_d;
  logic              ld_pend_q, ld_pend_d;
  // Keeps in_ready low until the first edge after reset release.
  logic              rdy_en_q;

  logic              is_load, is_store, accept;
  logic              sb_push, sb_pop;
  logic [XLEN-1:0]   sb_head_addr, sb_head_data;
  logic              unused_cm;

  assign is_load   = cntrl_m_in[CM_LOAD_BIT];
  assign is_store  = cntrl_m_in[CM_STORE_BIT] & ~cntrl_m_in[CM_LOAD_BIT];
  assign unused_cm = ^cntrl_m_in;

`ifdef MEM_SB_FWD_EN
  logic              fwd_hit;
  logic [XLEN-1:0]   fwd_data;
`endif

  mem_sb_fifo #(
    .XLEN     (XLEN),
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (sb_push),
    .push_addr  (alu_in),
    .push_data  (wdata_in),
    .pop        (sb_pop),
    .head_addr  (sb_head_addr),
    .head_data  (sb_head_data),
    .count      (sb_count)
`ifdef MEM_SB_FWD_EN
    ,
    .match_addr (alu_in),
    .match_hit  (fwd_hit),
    .match_data (fwd_data)
`endif
  );

  always_comb begin
    state_d       = state_q;
    out_valid_d   = stall ? out_valid_q : 1'b0;
    alu_out_d     = alu_out_q;
    mem_out_d     = mem_out_q;
    z_out_d       = z_out_q;
    cntrl_w_out_d = cntrl_w_out_q;
    ld_alu_d      = ld_alu_q;
    ld_z_d        = ld_z_q;
    ld_cw_d       = ld_cw_q;
    ld_data_d     = ld_data_q;
    ld_pend_d     = ld_pend_q;
    in_ready      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = '0;
    dmem_wdata    = '0;
    sb_push       = 1'b0;
    sb_pop        = 1'b0;

    // A pending load result owns the output registers, so nothing new enters.
    if (rdy_en_q && !stall && (state_q == ST_IDLE) && !ld_pend_q) begin
      if (is_load) begin
`ifdef MEM_SB_FWD_EN
        in_ready = 1'b1;
`else
        in_ready = (sb_count == '0);
`endif
      end else if (is_store) begin
        // Uses registered count: a same-cycle pop never makes room.
        in_ready = (sb_count < CW'(SB_DEPTH));
      end else begin
        in_ready = 1'b1;
      end
    end
    accept = in_valid && in_ready;

    case (state_q)
      ST_IDLE: begin
        if (sb_count != '0) begin
          dmem_req   = 1'b1;
          dmem_we    = 1'b1;
          dmem_addr  = sb_head_addr;
          dmem_wdata = sb_head_data;
          sb_pop     = dmem_gnt;
        end
        if (accept && is_load) begin
`ifdef MEM_SB_FWD_EN
          if (fwd_hit) begin
            out_valid_d   = 1'b1;
            alu_out_d     = alu_in;
            mem_out_d     = fwd_data;
            z_out_d       = Z_in;
            cntrl_w_out_d = cntrl_w_in;
          end else
`endif
          begin
            state_d  = ST_LD_REQ;
            ld_alu_d = alu_in;
            ld_z_d   = Z_in;
            ld_cw_d  = cntrl_w_in;
          end
        end else if (accept) begin
          out_valid_d   = 1'b1;
          alu_out_d     = alu_in;
          mem_out_d     = '0;
          z_out_d       = Z_in;
          cntrl_w_out_d = cntrl_w_in;
          sb_push       = is_store;
        end
        if (ld_pend_q && !stall) begin
          out_valid_d   = 1'b1;
          alu_out_d     = ld_alu_q;
          mem_out_d     = ld_data_q;
          z_out_d       = ld_z_q;
          cntrl_w_out_d = ld_cw_q;
          ld_pend_d     = 1'b0;
        end
      end
      ST_LD_REQ: begin
        dmem_req  = 1'b1;
        dmem_addr = ld_alu_q;
        if (dmem_gnt) state_d = ST_LD_WAIT;
      end
      ST_LD_WAIT: begin
        if (dmem_rvalid) begin
          state_d = ST_IDLE;
          if (!stall) begin
            out_valid_d   = 1'b1;
            alu_out_d     = ld_alu_q;
            mem_out_d     = dmem_rdata;
            z_out_d       = ld_z_q;
            cntrl_w_out_d = ld_cw_q;
          end else begin
            ld_pend_d = 1'b1;
            ld_data_d = dmem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      out_valid_q   <= 1'b0;
      alu_out_q     <= '0;
      mem_out_q     <= '0;
      z_out_q       <= '0;
      cntrl_w_out_q <= '0;
      ld_alu_q      <= '0;
      ld_z_q        <= '0;
      ld_cw_q       <= '0;
      ld_data_q     <= '0;
      ld_pend_q     <= 1'b0;
      rdy_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      alu_out_q     <= alu_out_d;
      mem_out_q     <= mem_out_d;
      z_out_q       <= z_out_d;
      cntrl_w_out_q <= cntrl_w_out_d;
      ld_alu_q      <= ld_alu_d;
      ld_z_q        <= ld_z_d;
      ld_cw_q       <= ld_cw_d;
      ld_data_q     <= ld_data_d;
      ld_pend_q     <= ld_pend_d;
      rdy_en_q      <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_out     = alu_out_q;
  assign mem_out     = mem_out_q;
  assign Z_out       = z_out_q;
  assign cntrl_w_out = cntrl_w_out_q;

endmodule
